axis_pkt_sink: RTL and testbench

Synthesizable AXI4-Stream receiver (slave end) that accepts beats from any AXI-Stream master, buffers them in a show-ahead beat FIFO, and produces one status record per packet (byte count, beat count, TID/TDEST, protocol error flags). It is the RTL counterpart the VIP master driver exercises. It is the standard sink in loopback and DUT-level benches, and the ingress front end for packet-consuming blocks.

---
 rtl/axis_pkt_sink.sv | 209 ++++++++++++++++++++
 tb/tb_axis_pkt_sink.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_sink.sv
// axis_pkt_sink: AXI4-Stream slave; buffers beats in a show-ahead FIFO and emits one status record per packet.
// Latency: an accepted beat is on rd_* after one edge; pkt_done/pkt_* register one edge after the TLAST beat.
// Backpressure: S_TREADY low in reset and while the FIFO is full (plus throttle slots when AXIS_PKT_SINK_THROTTLE_EN).
module axis_pkt_sink #(
   parameter int DATA_W     = 32,
   parameter int ID_W       = 4,
   parameter int DEST_W     = 4,
   parameter int USER_W     = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16
`ifdef AXIS_PKT_SINK_THROTTLE_EN
   ,
   parameter int THROTTLE_PERIOD = 4
`endif
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  S_TVALID,
   output logic                  S_TREADY,
   input  logic [DATA_W-1:0]     S_TDATA,
   input  logic [DATA_W/8-1:0]   S_TSTRB,
   input  logic [DATA_W/8-1:0]   S_TKEEP,
   input  logic                  S_TLAST,
   input  logic [ID_W-1:0]       S_TID,
   input  logic [DEST_W-1:0]     S_TDEST,
   input  logic [USER_W-1:0]     S_TUSER,
   input  logic                  rd_en,
   output logic                  rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   output logic [DATA_W/8-1:0]   rd_keep,
   output logic                  rd_last,
   output logic [USER_W-1:0]     rd_user,
   output logic                  pkt_done,
   output logic [LEN_W-1:0]      pkt_bytes,
   output logic [LEN_W-1:0]      pkt_beats,
   output logic [ID_W-1:0]       pkt_id,
   output logic [DEST_W-1:0]     pkt_dest,
   output logic [2:0]            pkt_err,
   output logic [LEN_W-1:0]      pkt_count
);
   localparam int KEEP_W = DATA_W / 8;
   localparam int AW     = $clog2(FIFO_DEPTH);

   typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

   // ---------------- beat FIFO ----------------
   logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
   logic [KEEP_W-1:0] r_mem_keep [FIFO_DEPTH];
   logic              r_mem_last [FIFO_DEPTH];
   logic [USER_W-1:0] r_mem_user [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_full, w_push, w_pop, w_thr_block;

   assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
   assign rd_valid = (r_count != '0);
   assign w_push   = S_TVALID & S_TREADY;
   assign w_pop    = rd_en & rd_valid;
   // Full blocks ready outright, so a pop can never make room for a same-cycle push.
   assign S_TREADY = ~ARESET & ~w_full & ~w_thr_block;

   // Head is zeroed when empty so rd_* never shows stale or uninitialised storage.
   assign rd_data = rd_valid ? r_mem_data[r_rd_ptr] : '0;
   assign rd_keep = rd_valid ? r_mem_keep[r_rd_ptr] : '0;
   assign rd_last = rd_valid ? r_mem_last[r_rd_ptr] : 1'b0;
   assign rd_user = rd_valid ? r_mem_user[r_rd_ptr] : '0;

   // Storage write; contents need no reset because rd_* is qualified by occupancy.
   always_ff @(posedge ACLK) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= S_TDATA;
         r_mem_keep[r_wr_ptr] <= S_TKEEP;
         r_mem_last[r_wr_ptr] <= S_TLAST;
         r_mem_user[r_wr_ptr] <= S_TUSER;
      end
   end

   // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
      end
   end

`ifdef AXIS_PKT_SINK_THROTTLE_EN
   localparam int TW = $clog2(THROTTLE_PERIOD);
   logic [TW-1:0] r_thr;

   // Free-running slot counter; the last slot of every period refuses beats.
   always_ff @(posedge ACLK) begin
      if (ARESET)                                 r_thr <= '0;
      else if (r_thr == TW'(THROTTLE_PERIOD - 1)) r_thr <= '0;
      else                                        r_thr <= r_thr + TW'(1);
   end
   assign w_thr_block = (r_thr == TW'(THROTTLE_PERIOD - 1));
`else
   assign w_thr_block = 1'b0;
`endif

   // ---------------- packet tracking ----------------
   state_t             r_state, w_state_nxt;
   logic [LEN_W-1:0]   r_bytes, r_beats;
   logic [ID_W-1:0]    r_id;
   logic [DEST_W-1:0]  r_dest;
   logic [2:0]         r_err;
   logic               w_first;
   logic [LEN_W:0]     w_pop_cnt, w_byte_sum, w_beat_sum;
   logic [LEN_W-1:0]   w_bytes_nxt, w_beats_nxt;
   logic [ID_W-1:0]    w_id_nxt;
   logic [DEST_W-1:0]  w_dest_nxt;
   logic [2:0]         w_err_nxt;

   assign w_first = (r_state == ST_IDLE);

   // Packet state register.
   always_ff @(posedge ACLK) begin
      if (ARESET) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state: a last beat always returns to IDLE, so single-beat packets never leave it.
   always_comb begin
      w_state_nxt = r_state;
      if (w_push) w_state_nxt = S_TLAST ? ST_IDLE : ST_IN_PKT;
   end

   // Accumulator arithmetic; sums carry one extra bit so saturation is detected, not wrapped.
   always_comb begin
      w_pop_cnt = '0;
      for (int i = 0; i < KEEP_W; i++) w_pop_cnt = w_pop_cnt + {{LEN_W{1'b0}}, S_TKEEP[i]};
      w_byte_sum  = (w_first ? '0 : {1'b0, r_bytes}) + w_pop_cnt;
      w_beat_sum  = (w_first ? '0 : {1'b0, r_beats}) + (LEN_W+1)'(1);
      w_bytes_nxt = w_byte_sum[LEN_W] ? '1 : w_byte_sum[LEN_W-1:0];
      w_beats_nxt = w_beat_sum[LEN_W] ? '1 : w_beat_sum[LEN_W-1:0];
      w_id_nxt    = w_first ? S_TID   : r_id;
      w_dest_nxt  = w_first ? S_TDEST : r_dest;
      w_err_nxt   = (w_first ? 3'b000 : r_err)
                  | {w_byte_sum[LEN_W] | w_beat_sum[LEN_W],
                     |(S_TSTRB & ~S_TKEEP),
                     ~w_first & ((S_TID != r_id) | (S_TDEST != r_dest))};
   end

   // Running per-packet accumulators; cleared on the last beat so the next packet starts fresh.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_bytes <= '0;
         r_beats <= '0;
         r_id    <= '0;
         r_dest  <= '0;
         r_err   <= '0;
      end else if (w_push) begin
         if (S_TLAST) begin
            r_bytes <= '0;
            r_beats <= '0;
            r_err   <= '0;
         end else begin
            r_bytes <= w_bytes_nxt;
            r_beats <= w_beats_nxt;
            r_id    <= w_id_nxt;
            r_dest  <= w_dest_nxt;
            r_err   <= w_err_nxt;
         end
      end
   end

   logic               r_done;
   logic [LEN_W-1:0]   r_pkt_bytes, r_pkt_beats, r_pkt_count;
   logic [ID_W-1:0]    r_pkt_id;
   logic [DEST_W-1:0]  r_pkt_dest;
   logic [2:0]         r_pkt_err;

   // Status record: published on the last beat and held until the next packet completes.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_done      <= 1'b0;
         r_pkt_bytes <= '0;
         r_pkt_beats <= '0;
         r_pkt_id    <= '0;
         r_pkt_dest  <= '0;
         r_pkt_err   <= '0;
         r_pkt_count <= '0;
      end else begin
         r_done <= w_push & S_TLAST;
         if (w_push && S_TLAST) begin
            r_pkt_bytes <= w_bytes_nxt;
            r_pkt_beats <= w_beats_nxt;
            r_pkt_id    <= w_id_nxt;
            r_pkt_dest  <= w_dest_nxt;
            r_pkt_err   <= w_err_nxt;
            r_pkt_count <= r_pkt_count + LEN_W'(1);
         end
      end
   end

   assign pkt_done  = r_done;
   assign pkt_bytes = r_pkt_bytes;
   assign pkt_beats = r_pkt_beats;
   assign pkt_id    = r_pkt_id;
   assign pkt_dest  = r_pkt_dest;
   assign pkt_err   = r_pkt_err;
   assign pkt_count = r_pkt_count;
endmodule

// File: tb/tb_axis_pkt_sink.sv
// tb_axis_pkt_sink: directed test-plan steps plus randomized packets against a queue-based reference model.
// Inputs change 1ns after the rising edge; the model and DUT outputs are observed on the falling edge.
`timescale 1ns/1ps
module tb_axis_pkt_sink;
   localparam int DATA_W = 32, KEEP_W = 4, ID_W = 4, DEST_W = 4, USER_W = 1;
   localparam int FIFO_DEPTH = 16, LEN_W = 16, MAXV = 65535;
`ifdef AXIS_PKT_SINK_THROTTLE_EN
   localparam int PRE_PKTS = 12;
`else
   localparam int PRE_PKTS = 0;
`endif

   logic ACLK = 1'b0, ARESET = 1'b1;
   logic S_TVALID = 0, S_TREADY, S_TLAST = 0;
   logic [DATA_W-1:0] S_TDATA = '0;
   logic [KEEP_W-1:0] S_TSTRB = '0, S_TKEEP = '0;
   logic [ID_W-1:0]   S_TID = '0;
   logic [DEST_W-1:0] S_TDEST = '0;
   logic [USER_W-1:0] S_TUSER = '0;
   logic rd_en = 0, rd_valid, rd_last, pkt_done;
   logic [DATA_W-1:0] rd_data;
   logic [KEEP_W-1:0] rd_keep;
   logic [USER_W-1:0] rd_user;
   logic [LEN_W-1:0]  pkt_bytes, pkt_beats, pkt_count;
   logic [ID_W-1:0]   pkt_id;
   logic [DEST_W-1:0] pkt_dest;
   logic [2:0]        pkt_err;

   axis_pkt_sink dut (
      .ACLK(ACLK), .ARESET(ARESET), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
      .S_TDATA(S_TDATA), .S_TSTRB(S_TSTRB), .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST),
      .S_TID(S_TID), .S_TDEST(S_TDEST), .S_TUSER(S_TUSER),
      .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_keep(rd_keep),
      .rd_last(rd_last), .rd_user(rd_user), .pkt_done(pkt_done),
      .pkt_bytes(pkt_bytes), .pkt_beats(pkt_beats), .pkt_id(pkt_id),
      .pkt_dest(pkt_dest), .pkt_err(pkt_err), .pkt_count(pkt_count));

   always #5 ACLK = ~ACLK;

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [DATA_W-1:0] d; logic [KEEP_W-1:0] k; logic l; logic [USER_W-1:0] u; } beat_t;
   typedef struct { int bytes; int beats; int id; int dest; logic [2:0] err; int cnt; } st_t;
   beat_t q[$];
   st_t   exp_st[$];
   st_t   mst;
   bit    m_in = 0;
   int    m_bytes, m_beats, m_id, m_dest, m_cnt = 0, n_done = 0;
   logic [2:0] m_err;

   always @(negedge ACLK) begin
      chk("pkt_done", pkt_done, exp_st.size() != 0);
      if (pkt_done && exp_st.size() != 0) begin
         mst = exp_st.pop_front();
         n_done++;
         chk("pkt_bytes", pkt_bytes, mst.bytes);
         chk("pkt_beats", pkt_beats, mst.beats);
         chk("pkt_id",    pkt_id,    mst.id);
         chk("pkt_dest",  pkt_dest,  mst.dest);
         chk("pkt_err",   pkt_err,   mst.err);
         chk("pkt_count", pkt_count, mst.cnt);
      end
      chk("rd_valid", rd_valid, q.size() != 0);
`ifndef AXIS_PKT_SINK_THROTTLE_EN
      chk("s_tready", S_TREADY, !ARESET && q.size() < FIFO_DEPTH);
`endif
      if (rd_en && rd_valid && q.size() != 0) begin
         chk("rd_data", rd_data, q[0].d);
         chk("rd_keep", rd_keep, q[0].k);
         chk("rd_last", rd_last, q[0].l);
         chk("rd_user", rd_user, q[0].u);
         void'(q.pop_front());
      end
      if (S_TVALID && S_TREADY) begin
         q.push_back('{S_TDATA, S_TKEEP, S_TLAST, S_TUSER});
         if (!m_in) begin
            m_bytes = 0; m_beats = 0; m_err = 3'b000;
            m_id = int'(S_TID); m_dest = int'(S_TDEST); m_in = 1;
         end
         m_bytes += $countones(S_TKEEP);
         m_beats += 1;
         if (int'(S_TID) != m_id || int'(S_TDEST) != m_dest) m_err[0] = 1'b1;
         if ((S_TSTRB & ~S_TKEEP) != 0) m_err[1] = 1'b1;
         if (m_bytes > MAXV) begin m_bytes = MAXV; m_err[2] = 1'b1; end
         if (m_beats > MAXV) begin m_beats = MAXV; m_err[2] = 1'b1; end
         if (S_TLAST) begin
            m_cnt = (m_cnt + 1) % (MAXV + 1);
            exp_st.push_back('{m_bytes, m_beats, m_id, m_dest, m_err, m_cnt});
            m_in = 0;
         end
      end
      if (ARESET) begin
         q.delete(); exp_st.delete(); m_in = 0; m_cnt = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   bit rd_rand = 0;

   task automatic step();
      @(posedge ACLK); #1;
      if (rd_rand) rd_en = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [KEEP_W-1:0] keep, input logic [KEEP_W-1:0] strb,
                       input logic last, input logic [ID_W-1:0] id, input logic [DEST_W-1:0] dest);
      bit ok = 0;
      S_TVALID = 1; S_TDATA = $urandom; S_TKEEP = keep; S_TSTRB = strb; S_TLAST = last;
      S_TID = id; S_TDEST = dest; S_TUSER = 1'($urandom);
      for (int t = 0; t < 200; t++) begin
         @(negedge ACLK); ok = S_TREADY;
         step();
         if (ok) break;
      end
      if (!ok) chk("accept_timeout", ok, 1);
      S_TVALID = 0;
   endtask

   int acc, cur, d0;

   initial begin
      // reset values
      idle(3);
      @(negedge ACLK);
      chk("rst_tready", S_TREADY, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_pkt_bytes", pkt_bytes, 0);
      chk("rst_pkt_beats", pkt_beats, 0);
      chk("rst_pkt_err", pkt_err, 0);
      chk("rst_pkt_count", pkt_count, 0);
      step();
      ARESET = 0;
`ifdef AXIS_PKT_SINK_THROTTLE_EN
      // deterministic throttle: every 4th cycle refuses
      rd_en = 1; acc = 0;
      S_TVALID = 1; S_TKEEP = 4'hF; S_TSTRB = 4'hF; S_TLAST = 1;
      for (int c = 0; c < 16; c++) begin
         S_TDATA = $urandom;
         @(negedge ACLK);
         chk("thr_tready", S_TREADY, (c % 4) != 3);
         if (S_TREADY) acc++;
         step();
      end
      S_TVALID = 0;
      chk("thr_accepted", acc, 12);
`else
      @(negedge ACLK);
      chk("tready_after_reset", S_TREADY, 1);
      step();
`endif

      // T1: 4-beat packet, TID=2 TDEST=5
      rd_en = 1; d0 = n_done;
      for (int b = 0; b < 4; b++) send(4'hF, 4'hF, b == 3, 4'd2, 4'd5);
      idle(4);
      chk("t1_done", n_done - d0, 1);
      chk("t1_bytes", pkt_bytes, 16);
      chk("t1_beats", pkt_beats, 4);
      chk("t1_id", pkt_id, 2);
      chk("t1_dest", pkt_dest, 5);
      chk("t1_err", pkt_err, 0);
      chk("t1_count", pkt_count, PRE_PKTS + 1);
      chk("t1_drained", rd_valid, 0);

      // T2: fill to full with rd_en low, then a single pop
      rd_en = 0; acc = 0; cur = -1; d0 = n_done;
      S_TKEEP = 4'hF; S_TSTRB = 4'hF; S_TID = 1; S_TDEST = 1;
      for (int c = 0; c < 24; c++) begin
         if (cur != acc) begin
            S_TDATA = $urandom; S_TUSER = 1'($urandom); S_TLAST = (acc == 16); cur = acc;
         end
         S_TVALID = 1;
         @(negedge ACLK);
         if (S_TREADY) acc++;
         step();
      end
      chk("t2_accepted", acc, 16);
      chk("t2_full_tready", S_TREADY, 0);
      chk("t2_full_valid", rd_valid, 1);
      rd_en = 1; step(); rd_en = 0;
`ifndef AXIS_PKT_SINK_THROTTLE_EN
      chk("t2_tready_after_pop", S_TREADY, 1);
`endif
      send(S_TKEEP, S_TSTRB, 1'b1, S_TID, S_TDEST);
`ifndef AXIS_PKT_SINK_THROTTLE_EN
      chk("t2_refull_tready", S_TREADY, 0);
`endif
      rd_en = 1; idle(22);
      chk("t2_done", n_done - d0, 1);
      chk("t2_beats", pkt_beats, 17);
      chk("t2_bytes", pkt_bytes, 68);

      // T3: partial last beat with stray strobe
      send(4'hF, 4'hF, 0, 4'd3, 4'd3);
      send(4'hF, 4'hF, 0, 4'd3, 4'd3);
      send(4'h3, 4'h7, 1, 4'd3, 4'd3);
      idle(3);
      chk("t3_bytes", pkt_bytes, 10);
      chk("t3_beats", pkt_beats, 3);
      chk("t3_err", pkt_err, 3'b010);

      // T4: TDEST change mid-packet
      send(4'hF, 4'hF, 0, 4'd1, 4'd5);
      send(4'hF, 4'hF, 0, 4'd1, 4'd6);
      send(4'hF, 4'hF, 1, 4'd1, 4'd5);
      idle(3);
      chk("t4_err", pkt_err, 3'b001);
      chk("t4_dest", pkt_dest, 5);
      chk("t4_bytes", pkt_bytes, 12);

      // T5: reset after beat 2 of 4, then 1-beat packet
      send(4'hF, 4'hF, 0, 4'd4, 4'd4);
      send(4'hF, 4'hF, 0, 4'd4, 4'd4);
      d0 = n_done;
      ARESET = 1; step();
      chk("t5_rst_valid", rd_valid, 0);
      chk("t5_rst_count", pkt_count, 0);
      ARESET = 0;
      send(4'h1, 4'h1, 1, 4'd7, 4'd2);
      idle(3);
      chk("t5_done", n_done - d0, 1);
      chk("t5_bytes", pkt_bytes, 1);
      chk("t5_beats", pkt_beats, 1);
      chk("t5_count", pkt_count, 1);

      // T6: random packets, random keeps (incl. null beats), occasional errors, random rd_en
      rd_rand = 1; d0 = n_done;
      for (int p = 0; p < 40; p++) begin
         logic [ID_W-1:0] id;
         logic [DEST_W-1:0] dest;
         int len;
         id = 4'($urandom); dest = 4'($urandom); len = $urandom_range(1, 6);
         for (int b = 0; b < len; b++) begin
            logic [KEEP_W-1:0] k;
            k = 4'($urandom);
            send(k, ($urandom_range(0, 5) == 0) ? 4'($urandom) : k, b == len - 1,
                 ($urandom_range(0, 7) == 0) ? 4'($urandom) : id, dest);
         end
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      rd_rand = 0; rd_en = 1; idle(30);
      chk("t6_done", n_done - d0, 40);
      chk("t6_fifo_empty", q.size(), 0);
      chk("t6_status_empty", exp_st.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
